// File: rtl/interrupt_sequencer.sv
// Hardware interrupt arbiter for the 65816 core: synchronizes NMI/IRQ/ABORT,
// selects the winner at opcode boundaries, supplies vectors and owns WAI/STP.
module interrupt_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        abort_n,
  input  logic        i_flag,
  input  logic        e,
  input  logic        boundary,
  input  logic        int_ack,
  input  logic        soft_int,
  input  logic        soft_cop,
  input  logic        wai_exec,
  input  logic        stp_exec,
  output logic        int_req,
  output logic [1:0]  int_kind,
  output logic [15:0] vector,
  output logic        halt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PENDING = 2'd1,
    ST_WAIT    = 2'd2,
    ST_STOP    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    K_RESET = 2'd0,
    K_NMI   = 2'd1,
    K_ABORT = 2'd2,
    K_IRQ   = 2'd3
  } kind_t;

  logic [SYNC_STAGES-1:0] nmi_sync, irq_sync, abort_sync;
  logic   nmi_s, irq_lvl, abort_s;
  logic   nmi_prev, abort_prev;
  logic   nmi_fall, abort_fall;
  logic   res_pending, nmi_latch, abort_latch;
  logic   irq_ok, any_req, wake;
  state_t state_q, state_d;
  kind_t  kind_q, kind_d, winner, kind_shown;
  logic   int_req_c;
  logic   clr_res, clr_nmi, clr_abort;

  // Synchronizers run on every clk so slow cpu_en rates do not stretch latency.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, making the shift chain order-independent.
  always_ff @(posedge clk) begin
    if (reset) begin
      nmi_sync   <= '1;
      irq_sync   <= '1;
      abort_sync <= '1;
    end else begin
      nmi_sync   <= {nmi_sync[SYNC_STAGES-2:0], nmi_n};
      irq_sync   <= {irq_sync[SYNC_STAGES-2:0], irq_n};
      abort_sync <= {abort_sync[SYNC_STAGES-2:0], abort_n};
    end
  end

  assign nmi_s      = nmi_sync[SYNC_STAGES-1];
  assign abort_s    = abort_sync[SYNC_STAGES-1];
  assign irq_lvl    = ~irq_sync[SYNC_STAGES-1];
  assign nmi_fall   = nmi_prev & ~nmi_s;
  assign abort_fall = abort_prev & ~abort_s;

  assign irq_ok  = irq_lvl & ~i_flag;
  assign any_req = res_pending | nmi_latch | abort_latch | irq_ok;
  // WAI wakes on a raw IRQ level even when masked; execution then just resumes.
  assign wake    = res_pending | nmi_latch | abort_latch | irq_lvl;

  always_comb begin
    if (res_pending)      winner = K_RESET;
    else if (nmi_latch)   winner = K_NMI;
    else if (abort_latch) winner = K_ABORT;
    else if (irq_ok)      winner = K_IRQ;
    else                  winner = K_RESET;
  end

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    int_req_c = 1'b0;
    clr_res   = 1'b0;
    clr_nmi   = 1'b0;
    clr_abort = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (cpu_en && boundary && any_req) begin
          int_req_c = 1'b1;
          state_d   = ST_PENDING;
          kind_d    = winner;
        end else if (cpu_en && stp_exec) begin
          state_d = ST_STOP;
        end else if (cpu_en && wai_exec) begin
          state_d = ST_WAIT;
        end
      end
      ST_PENDING: begin
        int_req_c = 1'b1;
        if (cpu_en && int_ack) begin
          state_d = ST_RUN;
          unique case (kind_q)
            K_RESET: clr_res   = 1'b1;
            K_NMI:   clr_nmi   = 1'b1;
            K_ABORT: clr_abort = 1'b1;
            K_IRQ:   ;
          endcase
        end
      end
      ST_WAIT: begin
        if (cpu_en && wake) state_d = ST_RUN;
      end
      ST_STOP: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      kind_q      <= K_RESET;
      res_pending <= 1'b1;
      nmi_latch   <= 1'b0;
      abort_latch <= 1'b0;
      nmi_prev    <= 1'b1;
      abort_prev  <= 1'b1;
    end else if (cpu_en) begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      nmi_prev    <= nmi_s;
      abort_prev  <= abort_s;
      res_pending <= res_pending & ~clr_res;
      // A fresh edge wins over a same-cycle acknowledge, so no NMI is lost.
      nmi_latch   <= nmi_fall | (nmi_latch & ~clr_nmi);
      abort_latch <= abort_fall | (abort_latch & ~clr_abort);
    end
  end

  function automatic logic [15:0] hw_vector(input kind_t k, input logic emu);
    logic [15:0] v;
    unique case (k)
      K_RESET: v = 16'hFFFC;
      K_NMI:   v = emu ? 16'hFFFA : 16'hFFEA;
      K_ABORT: v = emu ? 16'hFFF8 : 16'hFFE8;
      K_IRQ:   v = emu ? 16'hFFFE : 16'hFFEE;
    endcase
    return v;
  endfunction

  function automatic logic [15:0] soft_vector(input logic cop, input logic emu);
    logic [15:0] v;
    if (cop) v = emu ? 16'hFFF4 : 16'hFFE4;
    else     v = emu ? 16'hFFFE : 16'hFFE6;
    return v;
  endfunction

  assign kind_shown = (state_q == ST_PENDING) ? kind_q : winner;

  always_comb begin
    int_req  = int_req_c & ~reset;
    halt     = ((state_q == ST_WAIT) || (state_q == ST_STOP)) & ~reset;
    int_kind = reset ? K_RESET : kind_shown;
    if (reset)
      vector = 16'hFFFC;
    else if (soft_int && !int_req_c)
      vector = soft_vector(soft_cop, e);
    else
      vector = hw_vector(kind_shown, e);
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: inputs change just after the falling
// edge, outputs are checked 1 time unit later, well clear of the rising edge.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_en;
  logic        nmi_n, irq_n, abort_n;
  logic        i_flag, e;
  logic        boundary, int_ack;
  logic        soft_int, soft_cop;
  logic        wai_exec, stp_exec;
  logic        int_req;
  logic [1:0]  int_kind;
  logic [15:0] vector;
  logic        halt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  interrupt_sequencer #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_en   (cpu_en),
    .nmi_n    (nmi_n),
    .irq_n    (irq_n),
    .abort_n  (abort_n),
    .i_flag   (i_flag),
    .e        (e),
    .boundary (boundary),
    .int_ack  (int_ack),
    .soft_int (soft_int),
    .soft_cop (soft_cop),
    .wai_exec (wai_exec),
    .stp_exec (stp_exec),
    .int_req  (int_req),
    .int_kind (int_kind),
    .vector   (vector),
    .halt     (halt)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; cpu_en = 1'b1;
    nmi_n = 1'b1; irq_n = 1'b1; abort_n = 1'b1;
    i_flag = 1'b1; e = 1'b0;
    boundary = 1'b0; int_ack = 1'b0;
    soft_int = 1'b0; soft_cop = 1'b0;
    wai_exec = 1'b0; stp_exec = 1'b0;

    // Reset state, then the pending RESET is taken at the first boundary.
    step(3); #1;
    check("rst_int_req", int_req, 0);
    check("rst_halt", halt, 0);
    check("rst_kind", int_kind, 0);
    check("rst_vector", vector, 16'hFFFC);
    reset = 1'b0; boundary = 1'b1; #1;
    check("res_req", int_req, 1);
    check("res_kind", int_kind, 0);
    check("res_vector", vector, 16'hFFFC);
    step(1); boundary = 1'b0; int_ack = 1'b1; #1;
    check("res_pending_req", int_req, 1);
    step(1); int_ack = 1'b0; boundary = 1'b1; #1;
    check("res_cleared", int_req, 0);
    boundary = 1'b0;

    // Native mode: IRQ and NMI together, NMI served first, then IRQ.
    e = 1'b0; i_flag = 1'b0; irq_n = 1'b0; nmi_n = 1'b0;
    step(4); boundary = 1'b1; #1;
    check("nmi_req", int_req, 1);
    check("nmi_kind", int_kind, 1);
    check("nmi_vector", vector, 16'hFFEA);
    step(1); boundary = 1'b0; int_ack = 1'b1; #1;
    check("nmi_pending_kind", int_kind, 1);
    step(1); int_ack = 1'b0; boundary = 1'b1; #1;
    check("irq_req", int_req, 1);
    check("irq_kind", int_kind, 3);
    check("irq_vector", vector, 16'hFFEE);
    step(1); boundary = 1'b0; int_ack = 1'b1;
    step(1); int_ack = 1'b0; irq_n = 1'b1; i_flag = 1'b1; nmi_n = 1'b1;
    step(4);

    // WAI in emulation mode: stays halted with no source, masked IRQ wakes it.
    e = 1'b1; wai_exec = 1'b1;
    step(1); wai_exec = 1'b0; #1;
    check("wai_halt", halt, 1);
    step(2); #1;
    check("wai_idle_halt", halt, 1);
    irq_n = 1'b0;
    step(1); #1;
    check("wai_sync_halt", halt, 1);
    step(4); #1;
    check("wai_woken", halt, 0);
    boundary = 1'b1; #1;
    check("irq_masked", int_req, 0);
    boundary = 1'b0; irq_n = 1'b1;
    step(3);

    // STP (issued together with WAI) ignores NMI/IRQ; only reset exits.
    wai_exec = 1'b1; stp_exec = 1'b1;
    step(1); wai_exec = 1'b0; stp_exec = 1'b0; #1;
    check("stp_halt", halt, 1);
    nmi_n = 1'b0; irq_n = 1'b0; i_flag = 1'b0;
    step(5); boundary = 1'b1; #1;
    check("stop_halt", halt, 1);
    check("stop_req", int_req, 0);
    boundary = 1'b0; nmi_n = 1'b1; irq_n = 1'b1; i_flag = 1'b1;
    step(3); reset = 1'b1;
    step(1); #1;
    check("stop_reset_halt", halt, 0);
    check("stop_reset_vector", vector, 16'hFFFC);
    reset = 1'b0; boundary = 1'b1; #1;
    check("stop_res_kind", int_kind, 0);
    check("stop_res_req", int_req, 1);
    step(1); boundary = 1'b0; int_ack = 1'b1;
    step(1); int_ack = 1'b0; boundary = 1'b1; #1;
    check("stop_nmi_cleared", int_req, 0);
    boundary = 1'b0;

    // Software interrupt vectors.
    step(1);
    soft_int = 1'b1; soft_cop = 1'b1; e = 1'b0; #1;
    check("cop_native", vector, 16'hFFE4);
    e = 1'b1; #1;
    check("cop_emu", vector, 16'hFFF4);
    soft_cop = 1'b0; #1;
    check("brk_emu", vector, 16'hFFFE);
    e = 1'b0; #1;
    check("brk_native", vector, 16'hFFE6);
    soft_int = 1'b0;

    // NMI arriving while an IRQ is pending does not preempt; cpu_en=0 freezes all.
    step(1); e = 1'b0; i_flag = 1'b0; irq_n = 1'b0;
    step(4); boundary = 1'b1; #1;
    check("pend_irq_kind", int_kind, 3);
    step(1); boundary = 1'b0; nmi_n = 1'b0;
    step(4); #1;
    check("no_preempt_kind", int_kind, 3);
    check("no_preempt_req", int_req, 1);
    cpu_en = 1'b0; int_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1); #1;
      check($sformatf("hold_req_%0d", i), int_req, 1);
      check($sformatf("hold_kind_%0d", i), int_kind, 3);
      check($sformatf("hold_vector_%0d", i), vector, 16'hFFEE);
    end
    cpu_en = 1'b1;
    step(1); int_ack = 1'b0; irq_n = 1'b1; i_flag = 1'b1; nmi_n = 1'b1;
    boundary = 1'b1; #1;
    check("late_nmi_kind", int_kind, 1);
    check("late_nmi_vector", vector, 16'hFFEA);
    step(1); boundary = 1'b0; int_ack = 1'b1;
    step(1); int_ack = 1'b0;

    // ABORT in emulation mode, then a stray acknowledge in RUN is ignored.
    e = 1'b1; abort_n = 1'b0;
    step(4); boundary = 1'b1; #1;
    check("abort_kind", int_kind, 2);
    check("abort_vector", vector, 16'hFFF8);
    step(1); boundary = 1'b0; int_ack = 1'b1;
    step(1); abort_n = 1'b1;
    step(1); int_ack = 1'b0; boundary = 1'b1; #1;
    check("abort_cleared", int_req, 0);
    check("abort_halt", halt, 0);
    boundary = 1'b0;

    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Arbitrates the 65816 CPU's hardware interrupt sources (RESET, NMI, ABORT, IRQ) at instruction boundaries.
- Tells the CPU controller when to enter the A_HARD_INT sequence instead of fetching the next opcode.
- Supplies the 16-bit vector address for both hardware interrupts and software interrupts (BRK/COP).
- Owns the WAI (wait-for-interrupt) and STP (stop) sleep states, and the wake-up from them.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the synchronizer on each of nmi_n, irq_n and abort_n (minimum 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_en  in  1  CPU cycle enable; all state except the input synchronizers advances only when cpu_en=1.
- nmi_n  in  1  NMI line, active low, edge-triggered, asynchronous.
- irq_n  in  1  IRQ line, active low, level-sensitive, asynchronous.
- abort_n  in  1  ABORT line, active low, edge-triggered, asynchronous.
- i_flag  in  1  P.I (interrupt disable) flag.
- e  in  1  emulation-mode flag.
- boundary  in  1  controller is about to fetch an opcode.
- int_ack  in  1  controller accepted int_req; one cpu_en cycle.
- soft_int  in  1  BRK/COP opcode decoded (A_SOFT_INT).
- soft_cop  in  1  with soft_int: 1=COP, 0=BRK.
- wai_exec  in  1  WAI instruction executing.
- stp_exec  in  1  STP instruction executing.
- int_req  out  1  next sequence must be A_HARD_INT.
- int_kind  out  2  0=RESET, 1=NMI, 2=ABORT, 3=IRQ; valid while int_req=1.
- vector  out  16  vector address for the pending or soft interrupt.
- halt  out  1  CPU must not advance the controller (WAI or STP).

Behaviour:
- Input synchronization:
  - SYNC_STAGES flops per line, running every clk cycle regardless of cpu_en; all three lines reset to 1.
  - Edge detection runs on the cpu_en domain: a 1→0 transition of synchronized nmi_n sets nmi_latch; the same on abort_n sets abort_latch.
  - irq_lvl = ~irq_n_sync (level, no latch).
- Reset:
  - On reset: res_pending=1, nmi_latch=0, abort_latch=0, state=RUN, int_req=0, int_kind=0, halt=0, vector=16'hFFFC.
  - Reset mid-operation (any state, including STOP) forces these values within the same clk cycle.
- Priority (highest first): RESET > NMI > ABORT > IRQ. IRQ counts only when irq_lvl & ~i_flag.
- States RUN, PENDING, WAIT, STOP:
  - RUN: on cpu_en & boundary & any request present → PENDING. int_req=1 combinationally in that cycle. int_kind and vector show the winner.
  - PENDING: int_req=1. int_kind is frozen at the winner chosen on PENDING entry; a later higher-priority arrival does not preempt. On int_ack → RUN, and the served source is cleared (res_pending, nmi_latch or abort_latch). IRQ needs no clear.
  - WAIT: entered from RUN when cpu_en & wai_exec; halt=1.
    - Any nmi_latch, abort_latch, res_pending or irq_lvl → RUN on the next cpu_en, halt=0.
    - irq_lvl wakes even when i_flag=1. The interrupt is then not taken; execution resumes at the next opcode.
  - STOP: entered from RUN when cpu_en & stp_exec; halt=1. Only reset exits.
- Simultaneous events:
  - A new NMI edge in the same cycle as int_ack of NMI leaves nmi_latch=1.
  - wai_exec and stp_exec together → STOP.
  - int_ack without int_req is ignored.
- Vector map, chosen by e:
  - Native (e=0): COP FFE4, BRK FFE6, ABORT FFE8, NMI FFEA, IRQ FFEE, RESET FFFC.
  - Emulation (e=1): COP FFF4, ABORT FFF8, NMI FFFA, RESET FFFC, IRQ/BRK FFFE.
  - RESET always uses FFFC.
  - When soft_int=1 and int_req=0, vector shows the soft vector; otherwise it shows the hardware winner.
- Latency:
  - nmi_n falling edge → nmi_latch set after SYNC_STAGES+1 cpu_en-aligned clocks, worst case.
  - int_req asserts in the same cycle as the boundary at which the request is visible.
- Outputs are held constant while cpu_en=0.

Test Plan:
- Reset then release, cpu_en=1, boundary=1 → int_req=1, int_kind=0, vector=FFFC; int_ack → int_req=0, res_pending cleared.
- e=0, i_flag=0, irq_n=0 with NMI edge in same cycle, boundary → int_kind=1, vector=FFEA; after int_ack, next boundary → int_kind=3, vector=FFEE.
- e=1, i_flag=1, irq_n=0, boundary → int_req=0; then wai_exec → halt=1, next cpu_en → halt=0, int_req stays 0.
- stp_exec → halt=1; NMI and IRQ pulses → halt remains 1; reset → halt=0, vector=FFFC.
- soft_int=1, soft_cop=1: e=0 → vector=FFE4; e=1 → FFF4. soft_int=1, soft_cop=0, e=1 → FFFE.
- NMI edge during PENDING of an IRQ → IRQ is served first (no preemption); on next boundary int_kind=1. cpu_en held 0 for 5 cycles mid-PENDING → outputs unchanged.
